ddr2_frame_burst_arbiter: RTL

//  Upstream client of ddr2_controller_phy local port. Arbitrates between a CMOS write stream (show-ahead

---
 rtl/ddr2_client_pkg.sv | 15 +
 rtl/ddr2_frame_addr_gen.sv | 62 ++++++
 rtl/ddr2_frame_burst_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ddr2_client_pkg.sv
// Shared types for the DDR2 local-port client: arbiter FSM states and grant owner.
package ddr2_client_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_REQ   = 2'd2
   } state_t;

   typedef enum logic {
      GR_WR = 1'b0,
      GR_RD = 1'b1
   } grant_t;

endpackage

// File: rtl/ddr2_frame_addr_gen.sv
// Frame-buffer burst address counter: steps by one burst, wraps at frame end with a
// done pulse, and supports a restart request that is deferred while a burst is open.
module ddr2_frame_addr_gen #(
   parameter int ADDR_W      = 25,
   parameter int BURST_LEN   = 4,
   parameter int FRAME_WORDS = 153600,
   parameter int FB_BASE     = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_busy,
   input  logic              i_adv,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_done
);

   localparam logic [ADDR_W:0]   LP_END  = (ADDR_W+1)'(FB_BASE + FRAME_WORDS);
   localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(FB_BASE);
   localparam logic [ADDR_W-1:0] LP_STEP = ADDR_W'(BURST_LEN);

   logic [ADDR_W-1:0] r_addr;
   logic              r_pend;
   logic              r_done;
   logic [ADDR_W:0]   w_sum;
   logic              w_wrap;

   assign w_sum  = {1'b0, r_addr} + {1'b0, LP_STEP};
   assign w_wrap = (w_sum == LP_END);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr <= LP_BASE;
         r_pend <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_adv) begin
            r_pend <= 1'b0;
            // A restart requested during the burst replaces the increment and suppresses done
            if (r_pend || i_start) begin
               r_addr <= LP_BASE;
            end else if (w_wrap) begin
               r_addr <= LP_BASE;
               r_done <= 1'b1;
            end else begin
               r_addr <= w_sum[ADDR_W-1:0];
            end
         end else if (i_start) begin
            if (i_busy) begin
               r_pend <= 1'b1;
            end else begin
               r_addr <= LP_BASE;
            end
         end
      end
   end

   assign o_addr = r_addr;
   assign o_done = r_done;

endmodule

// File: rtl/ddr2_frame_burst_arbiter.sv
// Round-robin client of the DDR2 local port: CMOS write bursts from a show-ahead FIFO and
// Ethernet read commands gated by read-FIFO space and the outstanding-beat budget.
module ddr2_frame_burst_arbiter
   import ddr2_client_pkg::*;
#(
   parameter int ADDR_W      = 25,
   parameter int DATA_W      = 32,
   parameter int BE_W        = 4,
   parameter int SIZE_W      = 3,
   parameter int BURST_LEN   = 4,
   parameter int FRAME_WORDS = 153600,
   parameter int FB_BASE     = 0,
   parameter int LVL_W       = 11,
   parameter int MAX_OUTST   = 16
) (
   input  logic              phy_clk,
   input  logic              reset_phy_clk,
   input  logic              local_init_done,
   input  logic              local_ready,
   output logic [ADDR_W-1:0] local_address,
   output logic [SIZE_W-1:0] local_size,
   output logic              local_burstbegin,
   output logic              local_write_req,
   output logic              local_read_req,
   output logic [DATA_W-1:0] local_wdata,
   output logic [BE_W-1:0]   local_be,
   input  logic [DATA_W-1:0] local_rdata,
   input  logic              local_rdata_valid,
   input  logic [LVL_W-1:0]  wr_fifo_level,
   input  logic [DATA_W-1:0] wr_fifo_dout,
   output logic              wr_fifo_rd_en,
   input  logic [LVL_W-1:0]  rd_fifo_space,
   output logic              rd_fifo_wr_en,
   output logic [DATA_W-1:0] rd_fifo_din,
   input  logic              rd_enable,
   input  logic              wr_frame_start,
   input  logic              rd_frame_start,
   output logic              wr_frame_done,
   output logic              rd_frame_done
);

   localparam logic [LVL_W:0]    LP_BL   = (LVL_W+1)'(BURST_LEN);
   localparam logic [LVL_W:0]    LP_BLM1 = (LVL_W+1)'(BURST_LEN - 1);
   localparam logic [LVL_W:0]    LP_MAX  = (LVL_W+1)'(MAX_OUTST);
   localparam logic [LVL_W:0]    LP_ONE  = (LVL_W+1)'(1);
   localparam logic [LVL_W-1:0]  LP_LVL  = LVL_W'(BURST_LEN);
   localparam logic [SIZE_W-1:0] LP_LAST = SIZE_W'(BURST_LEN - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   grant_t            r_last_grant;
   logic [SIZE_W-1:0] r_beat;
   logic [LVL_W:0]    r_outst;
   logic [LVL_W:0]    w_outst_need;
   logic              w_wr_elig;
   logic              w_rd_elig;
   logic              w_wr_acc;
   logic              w_wr_last;
   logic              w_rd_acc;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [ADDR_W-1:0] w_rd_addr;

   // Compare one bit wider than the FIFO level so the budget sum cannot overflow
   assign w_outst_need = r_outst + LP_BL;
   assign w_wr_elig    = local_init_done && (wr_fifo_level >= LP_LVL);
   assign w_rd_elig    = local_init_done && rd_enable &&
                         ({1'b0, rd_fifo_space} >= w_outst_need) && (w_outst_need <= LP_MAX);

   assign w_wr_acc  = (r_state == WR_BURST) && local_ready;
   assign w_wr_last = w_wr_acc && (r_beat == LP_LAST);
   assign w_rd_acc  = (r_state == RD_REQ) && local_ready;

   always_ff @(posedge phy_clk) begin
      if (reset_phy_clk) begin
         r_state      <= IDLE;
         r_last_grant <= GR_RD;
         r_beat       <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_wr_acc) begin
            r_beat <= w_wr_last ? '0 : r_beat + 1'b1;
         end
         if (w_wr_last) begin
            r_last_grant <= GR_WR;
         end else if (w_rd_acc) begin
            r_last_grant <= GR_RD;
         end
      end
   end

   always_ff @(posedge phy_clk) begin
      if (reset_phy_clk) begin
         r_outst <= '0;
      end else begin
         case ({w_rd_acc, local_rdata_valid})
            2'b10:   r_outst <= r_outst + LP_BL;
            2'b01:   r_outst <= r_outst - LP_ONE;
            2'b11:   r_outst <= r_outst + LP_BLM1;
            default: r_outst <= r_outst;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_wr_elig && w_rd_elig) begin
               w_state_nxt = (r_last_grant == GR_RD) ? WR_BURST : RD_REQ;
            end else if (w_wr_elig) begin
               w_state_nxt = WR_BURST;
            end else if (w_rd_elig) begin
               w_state_nxt = RD_REQ;
            end
         end
         WR_BURST: if (w_wr_last) w_state_nxt = IDLE;
         RD_REQ:   if (w_rd_acc)  w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      local_write_req  = 1'b0;
      local_read_req   = 1'b0;
      local_burstbegin = 1'b0;
      local_address    = '0;
      local_wdata      = '0;
      case (r_state)
         WR_BURST: begin
            local_write_req  = 1'b1;
            local_burstbegin = (r_beat == '0);
            local_address    = w_wr_addr;
            local_wdata      = wr_fifo_dout;
         end
         RD_REQ: begin
            local_read_req   = 1'b1;
            local_burstbegin = 1'b1;
            local_address    = w_rd_addr;
         end
         default: ;
      endcase
   end

   assign local_size    = SIZE_W'(BURST_LEN);
   assign local_be      = '1;
   assign wr_fifo_rd_en = w_wr_acc;
   assign rd_fifo_wr_en = local_rdata_valid;
   assign rd_fifo_din   = local_rdata;

   ddr2_frame_addr_gen #(
      .ADDR_W      (ADDR_W),
      .BURST_LEN   (BURST_LEN),
      .FRAME_WORDS (FRAME_WORDS),
      .FB_BASE     (FB_BASE)
   ) u_wr_addr (
      .i_clk   (phy_clk),
      .i_rst   (reset_phy_clk),
      .i_start (wr_frame_start),
      .i_busy  (r_state == WR_BURST),
      .i_adv   (w_wr_last),
      .o_addr  (w_wr_addr),
      .o_done  (wr_frame_done)
   );

   ddr2_frame_addr_gen #(
      .ADDR_W      (ADDR_W),
      .BURST_LEN   (BURST_LEN),
      .FRAME_WORDS (FRAME_WORDS),
      .FB_BASE     (FB_BASE)
   ) u_rd_addr (
      .i_clk   (phy_clk),
      .i_rst   (reset_phy_clk),
      .i_start (rd_frame_start),
      .i_busy  (r_state == RD_REQ),
      .i_adv   (w_rd_acc),
      .o_addr  (w_rd_addr),
      .o_done  (rd_frame_done)
   );

endmodule
